// File: rtl/mouse_pkg.sv
// mouse_pkg: shared types and widths for the mouse tracker.
//   state_t     - tracker FSM state encoding
//   X_WIDTH     - width of the X position
//   DELTA_WIDTH - width of the signed X movement
package mouse_pkg;

   localparam int unsigned X_WIDTH     = 16;
   localparam int unsigned DELTA_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_IDLE  = 2'd1,
      ST_APPLY = 2'd2
   } state_t;

endpackage : mouse_pkg

// File: rtl/button_debounce.sv
// button_debounce: synchronises the raw active-low button and, optionally,
// filters it so a change is accepted only after it has been stable.
// Optional feature macro: MOUSE_TRACKER_DEBOUNCE_EN
//   defined   - output changes after the synchronised button has differed
//               from it for DEBOUNCE_CYCLES consecutive cycles
//   undefined - output is the synchroniser output (2-cycle latency)
// Ports:
//   clock          in   sole clock, rising edge
//   reset_         in   asynchronous active-low reset
//   button_raw_    in   asynchronous raw button, active-low
//   mouse_pressed_ out  conditioned button, active-low
module button_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic clock,
   input  logic reset_,
   input  logic button_raw_,
   output logic mouse_pressed_
);

   logic r_sync1;
   logic r_sync2;

   if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
      $error("button_debounce: DEBOUNCE_CYCLES must be at least 1");
   end

   // Two-flop synchroniser; idles released (1) out of reset.
   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= button_raw_;
         r_sync2 <= r_sync1;
      end
   end

`ifdef MOUSE_TRACKER_DEBOUNCE_EN
   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic [CNT_W-1:0] r_cnt;
   logic             r_pressed;

   // Count consecutive disagreeing cycles; any agreement restarts the count.
   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         r_cnt     <= '0;
         r_pressed <= 1'b1;
      end else if (r_sync2 != r_pressed) begin
         if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_pressed <= r_sync2;
            r_cnt     <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end else begin
         r_cnt <= '0;
      end
   end

   assign mouse_pressed_ = r_pressed;
`else
   assign mouse_pressed_ = r_sync2;
`endif

endmodule : button_debounce

// File: rtl/mouse_tracker.sv
// mouse_tracker: accepts signed X deltas over a valid/ready handshake and
// keeps a clamped X position in [0, X_MAX]; conditions the mouse button.
// Optional feature macro: MOUSE_TRACKER_DEBOUNCE_EN (see button_debounce).
// Ports:
//   clock          in   sole clock, rising edge
//   reset_         in   asynchronous active-low reset
//   delta_valid    in   delta_x is valid
//   delta_ready    out  block can accept delta_x (IDLE only)
//   delta_x        in   signed 8-bit X movement
//   button_raw_    in   asynchronous raw button, active-low
//   mouse_x        out  clamped X position, unsigned
//   mouse_pressed_ out  conditioned button, active-low
//   moved          out  one-cycle pulse when mouse_x changes
module mouse_tracker
   import mouse_pkg::*;
#(
   parameter logic [X_WIDTH-1:0] X_MAX           = 16'd639,
   parameter int unsigned        DEBOUNCE_CYCLES = 4
) (
   input  logic                   clock,
   input  logic                   reset_,
   input  logic                   delta_valid,
   output logic                   delta_ready,
   input  logic [DELTA_WIDTH-1:0] delta_x,
   input  logic                   button_raw_,
   output logic [X_WIDTH-1:0]     mouse_x,
   output logic                   mouse_pressed_,
   output logic                   moved
);

   // One guard bit beyond the 17 needed so X_MAX near 2^16-1 cannot wrap.
   localparam int unsigned SUM_W = X_WIDTH + 2;

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [DELTA_WIDTH-1:0]   r_delta;
   logic [X_WIDTH-1:0]       r_mouse_x;
   logic                     r_moved;
   logic                     r_delta_ready;

   logic                     w_accept;
   logic signed [SUM_W-1:0]  w_sum;
   logic [X_WIDTH-1:0]       w_clamped;
   logic [X_WIDTH-1:0]       w_mouse_x_nxt;
   logic                     w_moved_nxt;
   logic                     w_ready_nxt;

   assign w_accept = delta_valid & r_delta_ready;

   // State register.
   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         r_state <= ST_INIT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_INIT:  w_state_nxt = ST_IDLE;
         ST_IDLE:  if (w_accept) w_state_nxt = ST_APPLY;
         ST_APPLY: w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_INIT;
      endcase
   end

   // Signed sum of zero-extended position and sign-extended delta, then clamp.
   always_comb begin
      w_sum = $signed({2'b00, r_mouse_x})
            + $signed({{(SUM_W - DELTA_WIDTH){r_delta[DELTA_WIDTH-1]}}, r_delta});
      if (w_sum < 0) begin
         w_clamped = '0;
      end else if (w_sum > $signed({2'b00, X_MAX})) begin
         w_clamped = X_MAX;
      end else begin
         w_clamped = w_sum[X_WIDTH-1:0];
      end
   end

   // Output logic: next values of the registered outputs.
   always_comb begin
      w_mouse_x_nxt = r_mouse_x;
      w_moved_nxt   = 1'b0;
      w_ready_nxt   = (w_state_nxt == ST_IDLE);
      if (r_state == ST_APPLY) begin
         w_mouse_x_nxt = w_clamped;
         w_moved_nxt   = (w_clamped != r_mouse_x);
      end
   end

   // Output and captured-delta registers; reset discards a pending delta.
   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         r_delta       <= '0;
         r_mouse_x     <= X_MAX >> 1;
         r_moved       <= 1'b0;
         r_delta_ready <= 1'b0;
      end else begin
         if (w_accept) begin
            r_delta <= delta_x;
         end
         r_mouse_x     <= w_mouse_x_nxt;
         r_moved       <= w_moved_nxt;
         r_delta_ready <= w_ready_nxt;
      end
   end

   assign mouse_x     = r_mouse_x;
   assign moved       = r_moved;
   assign delta_ready = r_delta_ready;

   // Button path is fully independent of the delta path.
   button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_button_debounce (
      .clock          (clock),
      .reset_         (reset_),
      .button_raw_    (button_raw_),
      .mouse_pressed_ (mouse_pressed_)
   );

endmodule : mouse_tracker

// File: tb/tb_mouse_tracker.sv
// Testbench for mouse_tracker: a cycle-level reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_mouse_tracker;

   localparam int XMAX = 639;
   localparam int DB_N = 4;
`ifdef MOUSE_TRACKER_DEBOUNCE_EN
   localparam int BTN_LAT = 2 + DB_N;
`else
   localparam int BTN_LAT = 2;
`endif

   logic        clock = 1'b0;
   logic        reset_ = 1'b1;
   logic        delta_valid = 1'b0;
   logic        delta_ready;
   logic [7:0]  delta_x = 8'd0;
   logic        button_raw_ = 1'b1;
   logic [15:0] mouse_x;
   logic        mouse_pressed_;
   logic        moved;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   mouse_tracker #(
      .X_MAX           (16'd639),
      .DEBOUNCE_CYCLES (DB_N)
   ) dut (
      .clock          (clock),
      .reset_         (reset_),
      .delta_valid    (delta_valid),
      .delta_ready    (delta_ready),
      .delta_x        (delta_x),
      .button_raw_    (button_raw_),
      .mouse_x        (mouse_x),
      .mouse_pressed_ (mouse_pressed_),
      .moved          (moved)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Reference model: position moves by the clamped delta one cycle after
   // acceptance; the block is ready on every cycle except the one after an
   // accept and the first one after reset; button follows the raw input
   // delayed two clocks (and, if enabled, held stable for DB_N cycles).
   int m_x       = XMAX / 2;
   bit m_moved   = 1'b0;
   bit m_ready   = 1'b0;
   bit m_pending = 1'b0;
   int m_delta   = 0;
   bit m_pressed = 1'b1;
   int m_run     = 0;
   bit m_hist[$] = '{1'b1, 1'b1, 1'b1};

   function automatic int clamp(input int v);
      if (v < 0) return 0;
      if (v > XMAX) return XMAX;
      return v;
   endfunction

   always @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         m_x = XMAX / 2; m_moved = 1'b0; m_ready = 1'b0; m_pending = 1'b0;
         m_delta = 0; m_pressed = 1'b1; m_run = 0;
         m_hist = '{1'b1, 1'b1, 1'b1};
      end else begin
         int nx;
         m_moved = 1'b0;
         if (m_pending) begin
            nx = clamp(m_x + m_delta);
            m_moved = (nx != m_x);
            m_x = nx;
            m_pending = 1'b0;
            m_ready = 1'b1;
         end else if (m_ready && delta_valid) begin
            m_pending = 1'b1;
            m_delta = int'($signed(delta_x));
            m_ready = 1'b0;
         end else begin
            m_ready = 1'b1;
         end
         m_hist.push_front(button_raw_);
`ifdef MOUSE_TRACKER_DEBOUNCE_EN
         if (m_hist[2] != m_pressed) begin
            m_run++;
            if (m_run == DB_N) begin
               m_pressed = m_hist[2];
               m_run = 0;
            end
         end else begin
            m_run = 0;
         end
`else
         m_pressed = m_hist[1];
`endif
         void'(m_hist.pop_back());
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clock) begin
      if (chk_en) begin
         check("model_mouse_x", int'(mouse_x), m_x);
         check("model_moved", int'(moved), int'(m_moved));
         check("model_delta_ready", int'(delta_ready), int'(m_ready));
         check("model_pressed", int'(mouse_pressed_), int'(m_pressed));
      end
   end

   // Present a delta and hold it until a rising edge sees ready; returns at
   // the falling edge after the accepting edge (block is then in APPLY).
   task automatic send(input int d);
      bit acc = 1'b0;
      bit t;
      delta_valid = 1'b1;
      delta_x = 8'(d);
      for (int i = 0; i < 20 && !acc; i++) begin
         t = delta_ready;
         @(negedge clock);
         if (t) acc = 1'b1;
      end
      delta_valid = 1'b0;
      check("send_accepted", int'(acc), 1);
   endtask

   task automatic apply_expect(input int d, input int exp_x, input int exp_mv);
      send(d);
      check("ready_low_in_apply", int'(delta_ready), 0);
      @(negedge clock);
      check("lit_mouse_x", int'(mouse_x), exp_x);
      check("lit_moved", int'(moved), exp_mv);
      @(negedge clock);
      check("lit_moved_cleared", int'(moved), 0);
   endtask

   task automatic measure_button(input bit level, input string name);
      int n = 0;
      bit done = 1'b0;
      button_raw_ = level;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clock);
         n++;
         if (mouse_pressed_ == level) done = 1'b1;
      end
      check(name, n, BTN_LAT);
   endtask

   initial begin
      int mv_seen;
      @(negedge clock);
      reset_ = 1'b0;
      @(negedge clock);
      chk_en = 1'b1;
      repeat (2) @(negedge clock);
      check("rst_mouse_x", int'(mouse_x), 319);
      check("rst_pressed", int'(mouse_pressed_), 1);
      check("rst_moved", int'(moved), 0);
      check("rst_ready", int'(delta_ready), 0);

      reset_ = 1'b1;
      #1 check("ready_first_cycle", int'(delta_ready), 0);
      @(negedge clock);
      check("ready_second_cycle", int'(delta_ready), 1);
      check("post_rst_mouse_x", int'(mouse_x), 319);

      // Basic move, walk down to 100, clamp at 0, walk up, clamp at X_MAX.
      apply_expect(10, 329, 1);
      apply_expect(-127, 202, 1);
      apply_expect(-102, 100, 1);
      apply_expect(-128, 0, 1);
      apply_expect(-1, 0, 0);
      apply_expect(0, 0, 0);
      apply_expect(127, 127, 1);
      apply_expect(127, 254, 1);
      apply_expect(127, 381, 1);
      apply_expect(127, 508, 1);
      apply_expect(92, 600, 1);
      apply_expect(127, 639, 1);
      apply_expect(1, 639, 0);
      apply_expect(0, 639, 0);
      apply_expect(-39, 600, 1);

      // Back-to-back requests: valid raised while ready is low.
      send(5);
      send(-3);
      send(7);
      repeat (3) @(negedge clock);
      check("b2b_mouse_x", int'(mouse_x), 609);

      // Button: short glitch, then held press and release.
      repeat (4) @(negedge clock);
      button_raw_ = 1'b0;
      repeat (3) @(negedge clock);
      button_raw_ = 1'b1;
`ifdef MOUSE_TRACKER_DEBOUNCE_EN
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         check("glitch_ignored", int'(mouse_pressed_), 1);
      end
`else
      repeat (8) @(negedge clock);
`endif
      measure_button(1'b0, "press_latency");
      repeat (10) @(negedge clock);
      measure_button(1'b1, "release_latency");
      repeat (10) @(negedge clock);

      // Simultaneous button and delta activity.
      button_raw_ = 1'b0;
      send(20);
      repeat (10) @(negedge clock);
      check("simul_mouse_x", int'(mouse_x), 629);
      check("simul_pressed", int'(mouse_pressed_), 0);
      button_raw_ = 1'b1;
      repeat (10) @(negedge clock);

      // Reset during APPLY discards the captured delta.
      send(50);
      #2 reset_ = 1'b0;
      repeat (2) @(negedge clock);
      reset_ = 1'b1;
      mv_seen = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         if (moved) mv_seen++;
      end
      check("rst_apply_mouse_x", int'(mouse_x), 319);
      check("rst_apply_no_moved", mv_seen, 0);
      apply_expect(-19, 300, 1);

      repeat (3) @(negedge clock);
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_mouse_tracker
